// File: rtl/c1_csum_ctrl_if.sv
// Word-source / result-consumer handshake bundle for the one's-complement checksum controller.
interface c1_csum_ctrl_if #(
    parameter int W  = 4,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          chk_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_ok;
    logic [CW-1:0] out_cnt;

    modport master (
        output in_valid, in_data, in_last, chk_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_ok, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, chk_mode, out_ready,
        output in_ready, out_valid, out_sum, out_ok, out_cnt
    );
endinterface

// File: rtl/c1_csum_ctrl.sv
// Streams words through an end-around-carry adder and presents a per-packet
// one's-complement checksum (generate) or a raw sum with a good-packet flag (check).
module c1_csum_ctrl #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    c1_csum_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, RESULT} state_t;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          mode;
    logic          acc_en;
    logic          res_hs;
    logic [W:0]    s;
    logic [W-1:0]  acc_next;

    assign acc_en   = bus.in_valid & bus.in_ready;
    assign res_hs   = bus.out_valid & bus.out_ready;
    assign s        = {1'b0, acc} + {1'b0, bus.in_data};
    // Folding the carry back in cannot overflow: the largest s is 2^(W+1)-2.
    assign acc_next = s[W-1:0] + {{(W-1){1'b0}}, s[W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (acc_en) state_next = bus.in_last ? RESULT : ACC;
            ACC:     if (acc_en && bus.in_last) state_next = RESULT;
            RESULT:  if (res_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state != RESULT);
        bus.out_valid = (state == RESULT);
        bus.out_sum   = mode ? acc : ~acc;
        bus.out_ok    = mode & (acc == {W{1'b1}});
        bus.out_cnt   = cnt;
    end

    // The first word of a packet latches the mode and restarts the sum from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            cnt  <= '0;
            mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_en) begin
                        mode <= bus.chk_mode;
                        acc  <= bus.in_data;
                        cnt  <= CNT_ONE;
                    end
                end
                ACC: begin
                    if (acc_en) begin
                        acc <= acc_next;
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                RESULT: begin
                    if (res_hs) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                default: begin
                    acc <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_c1_csum_ctrl.sv
// Scoreboard bench: packets are pushed with their expected checksum when issued,
// a monitor compares every cycle the controller presents a result.
module tb_c1_csum_ctrl;
    localparam int W  = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          ok;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   readyMode = 1;
    exp_t sb[$];

    c1_csum_ctrl_if #(.W(W), .CW(CW)) bus ();

    c1_csum_ctrl #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Reference: one's-complement sum of the whole packet, folded until it fits in W bits.
    function automatic exp_t model(input int words[$], input bit m);
        exp_t e;
        int   total = 0;
        int   modv  = 1 << W;
        foreach (words[i]) total += words[i];
        while (total >= modv) total = (total % modv) + (total / modv);
        e.sum = m ? W'(total) : ~W'(total);
        e.ok  = m && (total == modv - 1);
        e.cnt = (words.size() > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(words.size());
        return e;
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got sum 0x%0h expected no result", bus.out_sum);
                end else begin
                    e = sb[0];
                    checkOutput("out_sum", 32'(bus.out_sum), 32'(e.sum));
                    checkOutput("out_ok",  32'(bus.out_ok),  32'(e.ok));
                    checkOutput("out_cnt", 32'(bus.out_cnt), 32'(e.cnt));
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic sendWord(input logic [W-1:0] d, input logic last, input logic m);
        int   waitCycles = 0;
        logic rdy;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.chk_mode = m;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waitCycles++;
            if (waitCycles > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL word_accept_timeout: got in_ready 0 expected 1 within 200 cycles");
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        bus.in_last  = 1'($urandom);
        bus.chk_mode = 1'($urandom);
    endtask

    task automatic applyStimulus(input int words[$], input bit m, input int gapLo,
                                 input int gapHi, input bit flip);
        logic mm;
        sb.push_back(model(words, m));
        foreach (words[i]) begin
            repeat ($urandom_range(gapHi, gapLo)) begin
                @(posedge clk);
                #1;
            end
            mm = (i == 0) ? m : (flip ? 1'($urandom) : m);
            sendWord(W'(words[i]), (i == words.size() - 1), mm);
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid === 1'b1) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("[TB] FAIL %s: got %0d results pending expected 0 within 500 cycles", name, sb.size());
        end
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.out_valid !== 1'b1 && n < 100);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: got out_valid %b expected 1 within 100 cycles", name, bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string name);
        @(negedge clk);
        checkOutput({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({name, "_in_ready"},  32'(bus.in_ready),  32'd1);
        checkOutput({name, "_out_sum"},   32'(bus.out_sum),   32'hF);
        checkOutput({name, "_out_ok"},    32'(bus.out_ok),    32'd0);
        checkOutput({name, "_out_cnt"},   32'(bus.out_cnt),   32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w[$];
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.chk_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset");

        w = '{5};
        applyStimulus(w, 1'b0, 0, 0, 1'b0);
        waitDrain("gen_single");
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        w = '{9, 8};
        applyStimulus(w, 1'b0, 0, 0, 1'b0);
        w = '{15, 15};
        applyStimulus(w, 1'b0, 0, 0, 1'b0);
        waitDrain("gen_carry");

        w = '{9, 8, 13};
        applyStimulus(w, 1'b1, 0, 0, 1'b0);
        w = '{9, 8, 12};
        applyStimulus(w, 1'b1, 0, 0, 1'b0);
        w = '{9, 8, 13};
        applyStimulus(w, 1'b1, 0, 1, 1'b1);
        waitDrain("check_mode");

        // Held result under backpressure while the source keeps offering a word.
        readyMode = 0;
        w = '{3};
        applyStimulus(w, 1'b0, 0, 0, 1'b0);
        waitValid("bp_valid");
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h7;
        bus.in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_in_ready",  32'(bus.in_ready),  32'd0);
            checkOutput("bp_out_sum",   32'(bus.out_sum),   32'hC);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        readyMode = 1;
        waitDrain("bp_release");

        w = '{1, 2, 4};
        applyStimulus(w, 1'b0, 3, 3, 1'b0);
        waitDrain("src_stall");

        sendWord(4'h9, 1'b0, 1'b0);
        sendWord(4'h8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        checkIdle("midpkt_reset");
        w = '{3};
        applyStimulus(w, 1'b0, 0, 0, 1'b0);
        waitDrain("after_reset");

        readyMode = 0;
        w = '{5};
        applyStimulus(w, 1'b0, 0, 0, 1'b0);
        waitValid("result_valid");
        rst = 1'b1;
        readyMode = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        checkIdle("result_reset");

        w = '{1, 1, 1, 1, 1};
        applyStimulus(w, 1'b0, 0, 0, 1'b0);
        waitDrain("cnt_saturate");

        readyMode = 2;
        repeat (40) begin
            int len;
            w.delete();
            len = $urandom_range(6, 1);
            for (int i = 0; i < len; i++) w.push_back(int'($urandom_range(15, 0)));
            applyStimulus(w, 1'($urandom), 0, 2, 1'b1);
        end
        waitDrain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/c1_csum_ctrl.md
Name: c1_csum_ctrl

Overview:
- Sequencing controller that streams W-bit words through a one's-complement end-around-carry adder and accumulates a packet checksum.
- Sits between a word source (valid/ready) and a result consumer (valid/ready).
- Two modes, latched per packet:
  - Generate: outputs the complemented sum.
  - Check: outputs the raw sum and flags a good packet.

Parameters:
W, 4, datapath word width in bits
CW, 8, width of the word counter (saturating)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  source presents a word
in_ready  output  1  controller accepts a word this cycle
in_data  input  W  word to accumulate
in_last  input  1  qualifies in_data as the final word of the packet
chk_mode  input  1  0=generate, 1=check; sampled on the first word of a packet
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_sum  output  W  generate: ~acc; check: acc
out_ok  output  1  check mode: acc == all-ones; generate mode: 0
out_cnt  output  CW  number of words in the packet, saturating at 2^CW-1

Behaviour:
- Reset:
  - One cycle of rst=1 forces state=IDLE, acc=0, cnt=0, mode=0.
  - Outputs after reset: out_valid=0, in_ready=1, out_sum=all-ones (~0), out_ok=0, out_cnt=0.
  - rst has priority over every handshake in the same cycle.
  - Reset mid-packet or while a result is pending discards all state; no partial result is emitted.
- Accumulate step, identical in all states:
  - s = acc + in_data, computed at W+1 bits.
  - acc_next = s[W-1:0] + s[W], truncated to W bits.
  - The fold never overflows, since max s = 2^(W+1)-2.
- Accept condition: acc_en = in_valid & in_ready.
- FSM states: IDLE, ACC, RESULT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On acc_en: mode<=chk_mode; acc<=0 (+') in_data, i.e. acc<=in_data; cnt<=1.
  - Next state: RESULT if in_last, else ACC.
- ACC:
  - in_ready=1, out_valid=0.
  - On acc_en: acc<=acc_next; cnt<=cnt+1, holding at the max value.
  - Next state: RESULT if in_last, else stay in ACC.
  - chk_mode is ignored in this state.
- RESULT:
  - in_ready=0, out_valid=1.
  - out_sum, out_ok and out_cnt are registered and held stable until the handshake.
  - On out_valid & out_ready: acc<=0, cnt<=0, next state IDLE.
  - in_valid is ignored while in this state; no word is consumed.
- Latency:
  - out_valid rises in the cycle after the in_last word is accepted.
  - At most one word is accepted per cycle.
  - A new packet's first word is accepted no earlier than the cycle after the result handshake.
- Output decode from registered acc/mode:
  - out_sum = mode ? acc : ~acc.
  - out_ok = mode & (acc == {W{1'b1}}).
  - out_cnt = cnt.
- One's-complement zero: acc = all-ones (negative zero) is a legal sum.
  - Generate mode then outputs out_sum=0.
- in_valid=0 in IDLE or ACC: state holds.
- in_data and in_last are don't-care when in_valid=0.

Test Plan:
1. Gen, single word: 0x5 with in_last=1, chk_mode=0 -> next cycle out_valid=1, out_sum=0xA, out_ok=0, out_cnt=1; out_ready=1 -> IDLE with in_ready=1.
2. Gen, end-around carry: words 0x9, 0x8(last) -> acc=0x2 (0x11 folded), out_sum=0xD, out_cnt=2. Words 0xF, 0xF(last) -> acc=0xF, out_sum=0x0.
3. Check mode:
   - Words 0x9, 0x8, 0xD(last) with chk_mode=1 on the first word -> out_sum=0xF, out_ok=1, out_cnt=3.
   - Same packet with 0xC last -> out_sum=0xE, out_ok=0.
   - Toggling chk_mode after the first word has no effect.
4. Backpressure:
   - Packet 0x3(last), out_ready=0 for 5 cycles -> out_valid=1 and out_sum=0xC stable throughout; in_ready=0.
   - in_valid=1 with 0x7 during this window is not consumed.
   - out_ready=1 -> one handshake, then IDLE.
   - Source stalls (in_valid=0 for 3 cycles between words) leave acc unchanged.
5. Reset mid-operation:
   - Accept 0x9, 0x8, then rst=1 for one cycle -> out_valid=0, in_ready=1, out_cnt=0.
   - Next packet 0x3(last) -> out_sum=0xC, out_cnt=1.
   - rst asserted in RESULT with out_ready=1 -> no handshake counted, returns to IDLE.
6. Counter saturation: with CW=2, send 5 words of 0x1 (last on the 5th) -> out_cnt=3, out_sum=~0x5=0xA.
